bp_fe_mem_arbiter: RTL

BP_FE_MEM_ARBITER -- requirements
Module: bp_fe_mem_arbiter

---
 rtl/bp_fe_pkg.sv | 24 ++
 rtl/bsg_priority_encode.sv | 23 ++
 rtl/bp_fe_mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end memory arbiter: FSM state encoding,
// request-vector bit positions and a small pipeline helper.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_run    = 2'd0,
    e_drain  = 2'd1,
    e_fence  = 2'd2,
    e_fencei = 2'd3
  } bp_fe_mem_arb_state_e;

  // Request-vector positions; bit 0 is the highest priority.
  localparam int unsigned arb_req_num_lp = 4;
  localparam logic [1:0] arb_tlb_fence_idx_lp = 2'd0;
  localparam logic [1:0] arb_fill_idx_lp      = 2'd1;
  localparam logic [1:0] arb_fencei_idx_lp    = 2'd2;
  localparam logic [1:0] arb_fetch_idx_lp     = 2'd3;

  // Live fetch count from the two stage-valid bits (0..2, cannot wrap).
  function automatic logic [1:0] inflight_count(input logic s1, input logic s2);
    return {1'b0, s1} + {1'b0, s2};
  endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// Priority encoder: addr_o is the index of the lowest set bit of i,
// v_o flags that any bit is set.
module bsg_priority_encode #(
  parameter int width_p = 4,
  parameter int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0]       i,
  output logic [addr_width_lp-1:0] addr_o,
  output logic                     v_o
);

  // Scan high to low so the lowest set bit is the last (winning) write.
  always_comb begin
    addr_o = '0;
    v_o    = |i;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (i[k]) begin
        addr_o = addr_width_lp'(k);
      end
    end
  end

endmodule

// File: rtl/bp_fe_mem_arbiter.sv
// Front-end memory arbiter: steers ITLB fences, ITLB fills, icache fences and
// fetches onto the shared ITLB/icache ports, draining in-flight fetches before
// any fence is performed.
//
// Handshake: every requester raises its v_i with operands and holds them until
// the combinational yumi_o pulses high in a cycle; that cycle is the transfer.
module bp_fe_mem_arbiter
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p     = 39,
  parameter int vtag_width_p      = 27,
  parameter int tlb_entry_width_p = 34
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         fetch_v_i,
  input  logic [vaddr_width_p-1:0]     fetch_vaddr_i,
  output logic                         fetch_yumi_o,

  input  logic                         fill_v_i,
  input  logic [vtag_width_p-1:0]      fill_vtag_i,
  input  logic [tlb_entry_width_p-1:0] fill_entry_i,
  output logic                         fill_yumi_o,

  input  logic                         tlb_fence_v_i,
  output logic                         tlb_fence_yumi_o,

  input  logic                         fencei_v_i,
  output logic                         fencei_yumi_o,

  input  logic                         poison_i,
  input  logic                         icache_ready_i,

  output logic                         itlb_v_o,
  output logic                         itlb_w_o,
  output logic                         itlb_flush_o,
  output logic [vtag_width_p-1:0]      itlb_vtag_o,
  output logic [tlb_entry_width_p-1:0] itlb_entry_o,

  output logic                         icache_vaddr_v_o,
  output logic [vaddr_width_p-1:0]     icache_vaddr_o,
  output logic                         icache_fencei_v_o,

  output logic [1:0]                   inflight_o,
  output logic                         busy_o,
  output bp_fe_mem_arb_state_e         state_o
);

  bp_fe_mem_arb_state_e state_q, state_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  logic [arb_req_num_lp-1:0] req_vec;
  logic [1:0]                grant_addr;
  logic                      grant_v;
  logic                      fence_pending;
  bp_fe_mem_arb_state_e      fence_target;

  // A fetch only competes when the icache can take its address this cycle.
  assign req_vec = {fetch_v_i & icache_ready_i, fencei_v_i, fill_v_i, tlb_fence_v_i};

  bsg_priority_encode #(
    .width_p(arb_req_num_lp)
  ) u_req_pe (
    .i     (req_vec),
    .addr_o(grant_addr),
    .v_o   (grant_v)
  );

  assign fence_pending = tlb_fence_v_i | fencei_v_i;
  // When both fences are pending the ITLB flush goes first; the icache fence
  // is picked up again on the return to RUN.
  assign fence_target  = tlb_fence_v_i ? e_fence : e_fencei;

  assign inflight_o = inflight_count(s1_q, s2_q);
  assign busy_o     = (state_q != e_run);
  assign state_o    = state_q;

  // Next-state, issue strobes and yumis; strobes are forced low during reset.
  always_comb begin
    state_d           = state_q;
    s1_d              = 1'b0;
    s2_d              = s1_q & ~poison_i;
    fetch_yumi_o      = 1'b0;
    fill_yumi_o       = 1'b0;
    tlb_fence_yumi_o  = 1'b0;
    fencei_yumi_o     = 1'b0;
    itlb_v_o          = 1'b0;
    itlb_w_o          = 1'b0;
    itlb_flush_o      = 1'b0;
    icache_vaddr_v_o  = 1'b0;
    icache_fencei_v_o = 1'b0;
    itlb_vtag_o       = fetch_vaddr_i[vaddr_width_p-1 -: vtag_width_p];
    itlb_entry_o      = fill_entry_i;
    icache_vaddr_o    = fetch_vaddr_i;

    if (reset_n_i) begin
      case (state_q)
        e_run: begin
          // Any pending fence blocks both fills and fetches so that the fence
          // is ordered ahead of later ITLB and icache traffic.
          if (fence_pending) begin
            state_d = (inflight_o != 2'd0) ? e_drain : fence_target;
          end else if (grant_v && grant_addr == arb_fill_idx_lp) begin
            fill_yumi_o = 1'b1;
            itlb_v_o    = 1'b1;
            itlb_w_o    = 1'b1;
            itlb_vtag_o = fill_vtag_i;
          end else if (grant_v && grant_addr == arb_fetch_idx_lp) begin
            fetch_yumi_o     = 1'b1;
            itlb_v_o         = 1'b1;
            icache_vaddr_v_o = 1'b1;
            s1_d             = 1'b1;
          end
        end
        e_drain: begin
          if (inflight_o == 2'd0) begin
            state_d = fence_target;
          end
        end
        e_fence: begin
          itlb_flush_o     = 1'b1;
          tlb_fence_yumi_o = 1'b1;
          state_d          = e_run;
        end
        e_fencei: begin
          if (icache_ready_i) begin
            icache_fencei_v_o = 1'b1;
            fencei_yumi_o     = 1'b1;
            state_d           = e_run;
          end
        end
        default: state_d = e_run;
      endcase
    end
  end

  // State and fetch-pipeline registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_run;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

endmodule
